// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, registered decode, sync/DE delay pipe and RGB565 output stage.
// Optional macro VGA_TEST_PATTERN_EN replaces pixel_data_in with 8 vertical colour bars.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] pixel_data_in,
    output logic        vga_display_en,
    output logic [9:0]  vga_x_pos,
    output logic [9:0]  vga_y_pos,
    output logic        frame_start,
    output logic        line_start,
    output logic        vga_hs_o,
    output logic        vga_vs_o,
    output logic        vga_de_o,
    output logic [15:0] vga_rgb_o
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOT - 1);
    localparam logic        SYNC_OFF   = ~SYNC_POL;

    logic [10:0] h_cnt_reg, v_cnt_reg;
    logic [10:0] h_cnt_next, v_cnt_next;
    logic        active_next, hs_next, vs_next;
    logic [9:0]  x_reg, y_reg;
    logic        frame_start_reg, line_start_reg;
    logic [15:0] rgb_reg, rgb_next;

    // Bit 0 of each pipe is the registered raw decode; bit PIPE_DLY drives the connector.
    logic [PIPE_DLY:0] de_pipe_reg, hs_pipe_reg, vs_pipe_reg;

    always_comb begin
        active_next = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
        hs_next     = ((h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END)) ? SYNC_POL : SYNC_OFF;
        vs_next     = ((v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END)) ? SYNC_POL : SYNC_OFF;
        h_cnt_next  = h_cnt_reg + 11'd1;
        v_cnt_next  = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? 11'd0 : v_cnt_reg + 11'd1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [6:0] bar_edge;
    logic [2:0] bar_next;
    logic [2:0] bar_pipe_reg [PIPE_DLY];
    logic [15:0] pixel_unused;

    assign pixel_unused = pixel_data_in;

    // Thermometer of bar boundaries; its population count is the bar index.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_bar_edge
            assign bar_edge[gi] = (h_cnt_reg >= 11'((gi + 1) * BAR_W));
        end
    endgenerate

    always_comb begin
        bar_next = '0;
        for (int i = 0; i < 7; i++) begin
            bar_next = bar_next + {2'b00, bar_edge[i]};
        end
    end

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Bar index travels alongside DE so it arrives with the data-capture tap.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                bar_pipe_reg[i] <= '0;
            end
        end else begin
            bar_pipe_reg[0] <= bar_next;
            for (int i = 1; i < PIPE_DLY; i++) begin
                bar_pipe_reg[i] <= bar_pipe_reg[i-1];
            end
        end
    end

    assign rgb_next = de_pipe_reg[PIPE_DLY-1] ? bar_colour(bar_pipe_reg[PIPE_DLY-1]) : 16'h0000;
`else
    assign rgb_next = de_pipe_reg[PIPE_DLY-1] ? pixel_data_in : 16'h0000;
`endif

    // en=0 behaves exactly like rst so a re-enable starts a clean frame.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            de_pipe_reg     <= '0;
            hs_pipe_reg     <= {(PIPE_DLY+1){SYNC_OFF}};
            vs_pipe_reg     <= {(PIPE_DLY+1){SYNC_OFF}};
            rgb_reg         <= '0;
        end else begin
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            x_reg           <= active_next ? h_cnt_reg[9:0] : 10'd0;
            y_reg           <= active_next ? v_cnt_reg[9:0] : 10'd0;
            frame_start_reg <= (h_cnt_reg == 11'd0) && (v_cnt_reg == 11'd0);
            line_start_reg  <= (h_cnt_reg == 11'd0) && (v_cnt_reg < V_ACT_END);
            de_pipe_reg     <= {de_pipe_reg[PIPE_DLY-1:0], active_next};
            hs_pipe_reg     <= {hs_pipe_reg[PIPE_DLY-1:0], hs_next};
            vs_pipe_reg     <= {vs_pipe_reg[PIPE_DLY-1:0], vs_next};
            rgb_reg         <= rgb_next;
        end
    end

    assign vga_display_en = de_pipe_reg[0];
    assign vga_x_pos      = x_reg;
    assign vga_y_pos      = y_reg;
    assign frame_start    = frame_start_reg;
    assign line_start     = line_start_reg;
    assign vga_de_o       = de_pipe_reg[PIPE_DLY];
    assign vga_hs_o       = hs_pipe_reg[PIPE_DLY];
    assign vga_vs_o       = vs_pipe_reg[PIPE_DLY];
    assign vga_rgb_o      = rgb_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; expected outputs come from an arithmetic model of
// the raster position (cycle index modulo frame length), with randomized pixel data and event points.
module tb_vga_timing_gen;
    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VA = 8, VFP = 1, VS = 2, VBP = 2;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int P  = 3;
    localparam bit SP = 1'b0;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] pixel_data_in;
    logic        vga_display_en, frame_start, line_start, vga_hs_o, vga_vs_o, vga_de_o;
    logic [9:0]  vga_x_pos, vga_y_pos;
    logic [15:0] vga_rgb_o;
    logic [41:0] dut_vec;

    int checks = 0;
    int failures = 0;
    int t = -1;
    logic [15:0] seed;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(SP), .PIPE_DLY(P)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pixel_data_in(pixel_data_in),
        .vga_display_en(vga_display_en), .vga_x_pos(vga_x_pos), .vga_y_pos(vga_y_pos),
        .frame_start(frame_start), .line_start(line_start),
        .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o), .vga_de_o(vga_de_o), .vga_rgb_o(vga_rgb_o)
    );

    assign dut_vec = {vga_display_en, vga_x_pos, vga_y_pos, frame_start, line_start,
                      vga_hs_o, vga_vs_o, vga_de_o, vga_rgb_o};

    function automatic bit active_at(input int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic logic [15:0] pix_of(input int p);
        int h, v;
        h = p % HT;
        v = p / HT;
`ifdef VGA_TEST_PATTERN_EN
        case (h / (HA / 8))
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
`else
        return {6'(h), 10'(v)} ^ seed;
`endif
    endfunction

    // Expected output vector after the tt-th enabled edge of a fresh frame (tt<0: idle/reset).
    function automatic logic [41:0] model_out(input int tt);
        int p, q, h, v;
        logic de, fs, ls, dde, dhs, dvs;
        logic [9:0] x, y;
        logic [15:0] rgb;
        if (tt < 0) return {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, ~SP, ~SP, 1'b0, 16'h0000};
        p  = tt % FT;
        h  = p % HT;
        v  = p / HT;
        de = active_at(p);
        x  = de ? 10'(h) : 10'd0;
        y  = de ? 10'(v) : 10'd0;
        fs = (p == 0);
        ls = (h == 0) && (v < VA);
        dde = 1'b0; dhs = ~SP; dvs = ~SP; rgb = 16'h0000;
        if (tt >= P) begin
            q   = (tt - P) % FT;
            dde = active_at(q);
            dhs = ((q % HT) >= HA + HFP && (q % HT) < HA + HFP + HS) ? SP : ~SP;
            dvs = ((q / HT) >= VA + VFP && (q / HT) < VA + VFP + VS) ? SP : ~SP;
            rgb = dde ? pix_of(q) : 16'h0000;
        end
        return {de, x, y, fs, ls, dhs, dvs, dde, rgb};
    endfunction

    // Data for the pixel presented after edge k must be valid after edge k+P-1.
    task automatic drive_pixel();
        int k;
        k = t - (P - 1);
        if (t >= 0 && k >= 0 && active_at(k % FT)) pixel_data_in = pix_of(k % FT);
        else pixel_data_in = 16'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst && en) t++;
        else t = -1;
        drive_pixel();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dut_vec !== model_out(-1)) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, dut_vec, model_out(-1));
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (dut_vec !== model_out(t)) begin
            failures++;
            $display("FAIL first_edge_vec got=%h want=%h", dut_vec, model_out(t));
        end
        checks++;
        if ({frame_start, vga_display_en, vga_x_pos, vga_y_pos} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
            failures++;
            $display("FAIL first_edge_origin got fs=%b de=%b x=%0d y=%0d want fs=1 de=1 x=0 y=0",
                     frame_start, vga_display_en, vga_x_pos, vga_y_pos);
        end
    endtask

    task automatic test_two_frames();
        int fs_cnt = 0, ls_cnt = 0, hs_cnt = 0, vs_cnt = 0, last_fs = 0;
        for (int n = 0; n < 2 * FT + P; n++) begin
            tick();
            checks++;
            if (dut_vec !== model_out(t)) begin
                failures++;
                $display("FAIL frame_vec t=%0d got=%h want=%h", t, dut_vec, model_out(t));
            end
            if (frame_start) begin
                checks++;
                if (t - last_fs != FT) begin
                    failures++;
                    $display("FAIL fs_period got=%0d want=%0d", t - last_fs, FT);
                end
                last_fs = t;
            end
            if (t >= P && t < P + 2 * FT) begin
                fs_cnt += int'(frame_start);
                ls_cnt += int'(line_start);
                hs_cnt += int'(vga_hs_o === SP);
                vs_cnt += int'(vga_vs_o === SP);
            end
        end
        checks++;
        if (fs_cnt != 2) begin failures++; $display("FAIL fs_count got=%0d want=2", fs_cnt); end
        checks++;
        if (ls_cnt != 2 * VA) begin failures++; $display("FAIL ls_count got=%0d want=%0d", ls_cnt, 2 * VA); end
        checks++;
        if (hs_cnt != 2 * VT * HS) begin failures++; $display("FAIL hs_count got=%0d want=%0d", hs_cnt, 2 * VT * HS); end
        checks++;
        if (vs_cnt != 2 * VS * HT) begin failures++; $display("FAIL vs_count got=%0d want=%0d", vs_cnt, 2 * VS * HT); end
    endtask

    task automatic test_en_drop();
        int tx, ty, target, n;
        tx = $urandom_range(HA - 1, 1);
        ty = $urandom_range(VA - 1, 1);
        target = ty * HT + tx;
        n = 0;
        while ((t % FT) != target && n < 2 * FT) begin
            tick();
            n++;
            checks++;
            if (dut_vec !== model_out(t)) begin
                failures++;
                $display("FAIL pre_drop_vec t=%0d got=%h want=%h", t, dut_vec, model_out(t));
            end
        end
        if ((t % FT) != target) begin
            failures++;
            $display("FAIL en_drop_timeout got_pos=%0d want_pos=%0d", t % FT, target);
        end
        checks++;
        if (vga_x_pos !== 10'(tx) || vga_y_pos !== 10'(ty)) begin
            failures++;
            $display("FAIL drop_point got x=%0d y=%0d want x=%0d y=%0d", vga_x_pos, vga_y_pos, tx, ty);
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_vec !== model_out(-1)) begin
                failures++;
                $display("FAIL en_low_idle cyc=%0d got=%h want=%h", i, dut_vec, model_out(-1));
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if ({frame_start, vga_display_en, vga_x_pos, vga_y_pos, vga_de_o} !== {1'b1, 1'b1, 10'd0, 10'd0, 1'b0}) begin
            failures++;
            $display("FAIL restart_origin got fs=%b de=%b x=%0d y=%0d de_o=%b want fs=1 de=1 x=0 y=0 de_o=0",
                     frame_start, vga_display_en, vga_x_pos, vga_y_pos, vga_de_o);
        end
        for (int i = 0; i < 3 * HT; i++) begin
            tick();
            checks++;
            if (dut_vec !== model_out(t)) begin
                failures++;
                $display("FAIL restart_vec t=%0d got=%h want=%h", t, dut_vec, model_out(t));
            end
        end
    endtask

    task automatic test_rst_in_hsync();
        int th, tv, target, n;
        th = $urandom_range(HA + HFP + HS - 1, HA + HFP + P - 1);
        tv = $urandom_range(VT - 1, 0);
        target = tv * HT + th;
        n = 0;
        while ((t % FT) != target && n < 2 * FT) begin
            tick();
            n++;
            checks++;
            if (dut_vec !== model_out(t)) begin
                failures++;
                $display("FAIL pre_rst_vec t=%0d got=%h want=%h", t, dut_vec, model_out(t));
            end
        end
        if ((t % FT) != target) begin
            failures++;
            $display("FAIL rst_hsync_timeout got_pos=%0d want_pos=%0d", t % FT, target);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (vga_hs_o !== ~SP) begin
            failures++;
            $display("FAIL rst_hs_deassert got=%b want=%b", vga_hs_o, ~SP);
        end
        checks++;
        if (dut_vec !== model_out(-1)) begin
            failures++;
            $display("FAIL rst_mid_idle got=%h want=%h", dut_vec, model_out(-1));
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * HT; i++) begin
            tick();
            checks++;
            if (dut_vec !== model_out(t)) begin
                failures++;
                $display("FAIL post_rst_vec t=%0d got=%h want=%h", t, dut_vec, model_out(t));
            end
        end
    endtask

    initial begin
        seed = 16'($urandom);
        rst = 1'b1;
        en = 1'b0;
        pixel_data_in = '0;
        test_reset();
        test_two_frames();
        test_en_drop();
        test_rst_in_hsync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
